// File: rtl/tele_pkg.sv
// Shared types and constants for the telegram frame sequencer.
package tele_pkg;

   localparam int FRAME_BYTES = 10;

   localparam int IDX_TELE   = 0;
   localparam int IDX_REP    = 1;
   localparam int IDX_HIGH_H = 2;
   localparam int IDX_HIGH_L = 3;
   localparam int IDX_LOW_H  = 4;
   localparam int IDX_LOW_L  = 5;
   localparam int IDX_IMP_H  = 6;
   localparam int IDX_IMP_L  = 7;
   localparam int IDX_STOP_H = 8;
   localparam int IDX_STOP_L = 9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_IMP,
      ST_GAP,
      ST_STOP_IMP,
      ST_STOP_GAP
   } tele_state_t;

   typedef struct packed {
      logic [7:0]  tele;
      logic [7:0]  rep_no;
      logic [15:0] t_high;
      logic [15:0] t_low;
      logic [15:0] t_imp;
      logic [15:0] t_stop;
   } tele_frame_t;

   typedef logic [FRAME_BYTES-1:0][7:0] tele_bytes_t;

   // Byte index = arrival order; 16-bit fields arrive MSB first.
   function automatic tele_frame_t unpack_frame(input tele_bytes_t b);
      tele_frame_t f;
      f.tele   = b[IDX_TELE];
      f.rep_no = b[IDX_REP];
      f.t_high = {b[IDX_HIGH_H], b[IDX_HIGH_L]};
      f.t_low  = {b[IDX_LOW_H],  b[IDX_LOW_L]};
      f.t_imp  = {b[IDX_IMP_H],  b[IDX_IMP_L]};
      f.t_stop = {b[IDX_STOP_H], b[IDX_STOP_L]};
      return f;
   endfunction

endpackage

// File: rtl/tele_frame_sequencer_if.sv
// Byte stream from the upstream UART receiver into the sequencer.
interface tele_frame_sequencer_if;
   logic       rx_valid;
   logic [7:0] rx_byte;

   modport master (output rx_valid, output rx_byte);
   modport slave  (input  rx_valid, input  rx_byte);
endinterface

// File: rtl/tele_phase_timer.sv
// Loadable phase down-counter with prescaler. A load of duration D
// (0 treated as 1) produces a one-cycle o_expire pulse in the last of
// D*PRESCALE cycles, so a reload on that edge gives back-to-back phases.
module tele_phase_timer #(
   parameter int CNT_W    = 16,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_dur,
   output logic             o_expire
);

   localparam int             PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  PRE_TC = PW'(PRESCALE - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [PW-1:0]    r_pre;
   logic             r_active;

   assign o_expire = r_active && (r_cnt == '0) && (r_pre == '0);

   // Unit counter steps once per PRESCALE clocks; load overrides expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_pre    <= '0;
         r_active <= 1'b0;
      end else if (i_load) begin
         r_cnt    <= (i_dur == '0) ? '0 : i_dur - 1'b1;
         r_pre    <= PRE_TC;
         r_active <= 1'b1;
      end else if (o_expire) begin
         r_active <= 1'b0;
      end else if (r_active) begin
         if (r_pre == '0) begin
            r_pre <= PRE_TC;
            r_cnt <= r_cnt - 1'b1;
         end else begin
            r_pre <= r_pre - 1'b1;
         end
      end
   end

endmodule

// File: rtl/tele_frame_sequencer.sv
// Telegram frame sequencer: loads a 10-byte frame and replays it as a
// pulse waveform rep_no times. Optional macro TELE_SHADOW_BUF_EN adds a
// shadow frame buffer that fills during playback and chains on completion.
//
//  state       | meaning
//  ST_IDLE     | waiting for a frame, or launching a latched one
//  ST_IMP      | bit impulse, pulse_out high for t_imp
//  ST_GAP      | bit gap, low for t_high (bit=1) or t_low (bit=0)
//  ST_STOP_IMP | stop impulse, high for t_imp
//  ST_STOP_GAP | stop gap, low for t_stop; ends one repetition
module tele_frame_sequencer
   import tele_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int PRESCALE = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   tele_frame_sequencer_if.slave  rx,
   output logic                   pulse_out,
   output logic                   busy,
   output logic [3:0]             byte_count,
   output logic [7:0]             rep_count,
   output logic                   frame_done
);

   tele_bytes_t      r_bytes;
   logic [3:0]       r_byte_cnt;
   logic             r_start;
   tele_state_t      r_state, w_state_n;
   logic [2:0]       r_bit, w_bit_n;
   logic             r_busy, w_busy_n;
   logic [7:0]       r_rep_cnt, w_rep_n;
   logic             r_done, w_done_n;
   logic             w_load;
   logic [CNT_W-1:0] w_dur;
   logic             w_expire;
   logic             w_accept;
   logic             w_launch;
   logic             w_end;
   logic             w_sh_full;
   tele_frame_t      w_cfg;

   assign w_cfg    = unpack_frame(r_bytes);
   assign w_accept = rx.rx_valid && !r_busy && !r_start;
   assign w_launch = (r_state == ST_IDLE) && r_start;
   assign w_end    = (r_state == ST_STOP_GAP) && w_expire &&
                     ((r_rep_cnt + 8'd1) == w_cfg.rep_no);

`ifdef TELE_SHADOW_BUF_EN
   tele_bytes_t r_sh_bytes;
   logic [3:0]  r_sh_cnt;
   logic        w_xfer;
   logic        w_sh_accept;

   assign w_sh_full   = (r_sh_cnt == 4'(FRAME_BYTES));
   assign w_xfer      = w_end && w_sh_full;
   assign w_sh_accept = rx.rx_valid && r_busy && !w_sh_full;
   assign byte_count  = r_busy ? r_sh_cnt : r_byte_cnt;

   // Shadow frame fills only while a playback is running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_bytes <= '0;
         r_sh_cnt   <= '0;
      end else if (w_xfer) begin
         r_sh_cnt <= '0;
      end else if (w_sh_accept) begin
         r_sh_bytes[r_sh_cnt] <= rx.rx_byte;
         r_sh_cnt             <= r_sh_cnt + 1'b1;
      end
   end
`else
   assign w_sh_full  = 1'b0;
   assign byte_count = r_byte_cnt;
`endif

   // Active frame loader; the 10th byte arms a launch for the next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bytes    <= '0;
         r_byte_cnt <= '0;
         r_start    <= 1'b0;
      end else if (w_accept) begin
         r_bytes[r_byte_cnt] <= rx.rx_byte;
         r_byte_cnt          <= r_byte_cnt + 1'b1;
         if (r_byte_cnt == 4'(FRAME_BYTES - 1)) r_start <= 1'b1;
      end else if (w_launch) begin
         r_byte_cnt <= '0;
         r_start    <= 1'b0;
`ifdef TELE_SHADOW_BUF_EN
      end else if (w_xfer) begin
         r_bytes <= r_sh_bytes;
         r_start <= 1'b1;
`endif
      end
   end

   tele_phase_timer #(.CNT_W(CNT_W), .PRESCALE(PRESCALE)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_dur    (w_dur),
      .o_expire (w_expire)
   );

   // Playback state register and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_bit     <= '0;
         r_busy    <= 1'b0;
         r_rep_cnt <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_bit     <= w_bit_n;
         r_busy    <= w_busy_n;
         r_rep_cnt <= w_rep_n;
         r_done    <= w_done_n;
      end
   end

   // Phase sequencing: each phase expiry loads the next phase duration.
   always_comb begin
      w_state_n = r_state;
      w_bit_n   = r_bit;
      w_busy_n  = r_busy;
      w_rep_n   = r_rep_cnt;
      w_done_n  = 1'b0;
      w_load    = 1'b0;
      w_dur     = CNT_W'(w_cfg.t_imp);
      if (w_accept && (r_byte_cnt == '0)) w_rep_n = '0;
      unique case (r_state)
         ST_IDLE: begin
            if (r_start) begin
               w_rep_n = '0;
               if (w_cfg.rep_no == '0) begin
                  w_done_n = 1'b1;
                  w_busy_n = 1'b0;
               end else begin
                  w_state_n = ST_IMP;
                  w_bit_n   = 3'd7;
                  w_busy_n  = 1'b1;
                  w_load    = 1'b1;
               end
            end
         end
         ST_IMP: begin
            if (w_expire) begin
               w_state_n = ST_GAP;
               w_load    = 1'b1;
               w_dur     = w_cfg.tele[r_bit] ? CNT_W'(w_cfg.t_high) : CNT_W'(w_cfg.t_low);
            end
         end
         ST_GAP: begin
            if (w_expire) begin
               w_load = 1'b1;
               if (r_bit == '0) begin
                  w_state_n = ST_STOP_IMP;
               end else begin
                  w_state_n = ST_IMP;
                  w_bit_n   = r_bit - 1'b1;
               end
            end
         end
         ST_STOP_IMP: begin
            if (w_expire) begin
               w_state_n = ST_STOP_GAP;
               w_load    = 1'b1;
               w_dur     = CNT_W'(w_cfg.t_stop);
            end
         end
         ST_STOP_GAP: begin
            if (w_expire) begin
               w_rep_n = r_rep_cnt + 8'd1;
               if (w_end) begin
                  w_state_n = ST_IDLE;
                  w_done_n  = 1'b1;
                  w_busy_n  = w_sh_full;
               end else begin
                  w_state_n = ST_IMP;
                  w_bit_n   = 3'd7;
                  w_load    = 1'b1;
               end
            end
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   assign pulse_out  = (r_state == ST_IMP) || (r_state == ST_STOP_IMP);
   assign busy       = r_busy;
   assign rep_count  = r_rep_cnt;
   assign frame_done = r_done;

endmodule

// File: tb/tb_tele_frame_sequencer.sv
`timescale 1ns/1ps
module tb_tele_frame_sequencer;
   import tele_pkg::*;

   localparam int PRESCALE = 1;
`ifdef TELE_SHADOW_BUF_EN
   localparam bit INJECT_OK = 1'b0;
`else
   localparam bit INJECT_OK = 1'b1;
`endif

   typedef logic [7:0] frame_t [10];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pulse_out, busy, frame_done;
   logic [3:0] byte_count;
   logic [7:0] rep_count;

   tele_frame_sequencer_if rx_if();

   tele_frame_sequencer #(.CNT_W(16), .PRESCALE(PRESCALE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx_if),
      .pulse_out  (pulse_out),
      .busy       (busy),
      .byte_count (byte_count),
      .rep_count  (rep_count),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit exp_wave[$];

   function automatic int unsigned units(input logic [15:0] v);
      return ((v == 16'd0) ? 1 : int'(v)) * PRESCALE;
   endfunction

   // Reference waveform: per repetition, 8 bits MSB first then the stop symbol.
   task automatic build_wave(input frame_t f);
      int unsigned th, tl, ti, ts;
      th = units({f[2], f[3]});
      tl = units({f[4], f[5]});
      ti = units({f[6], f[7]});
      ts = units({f[8], f[9]});
      exp_wave.delete();
      for (int r = 0; r < int'(f[1]); r++) begin
         for (int b = 7; b >= 0; b--) begin
            repeat (ti) exp_wave.push_back(1'b1);
            repeat (f[0][b] ? th : tl) exp_wave.push_back(1'b0);
         end
         repeat (ti) exp_wave.push_back(1'b1);
         repeat (ts) exp_wave.push_back(1'b0);
      end
   endtask

   task automatic send_frame(input frame_t f);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rx_if.rx_valid = 1'b1;
         rx_if.rx_byte  = f[i];
      end
      @(negedge clk);
      rx_if.rx_valid = 1'b0;
   endtask

   // Call in the cycle after the 10th byte; follows playback to frame_done.
   task automatic run_playback(input string name, input frame_t f, input bit inject,
                               output int cycles);
      int werr, bad_at, bc_err, limit;
      bit seen;
      werr = 0; bad_at = -1; bc_err = 0; seen = 1'b0; cycles = 0;
      build_wave(f);
      limit = exp_wave.size() + 50;
      n_cmp++;
      if (byte_count !== 4'd10) begin
         n_err++; $display("FAIL %s byte_count_at_latch: got %0d want 10", name, byte_count);
      end
      while (!seen && cycles < limit) begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (cycles >= exp_wave.size()) begin
               werr++; if (bad_at < 0) bad_at = cycles;
            end else if (pulse_out !== exp_wave[cycles] || busy !== 1'b1) begin
               werr++; if (bad_at < 0) bad_at = cycles;
            end
            if (byte_count !== 4'd0) bc_err++;
            if (inject) begin
               rx_if.rx_valid = 1'($urandom_range(0, 1));
               rx_if.rx_byte  = 8'($urandom);
            end
            cycles++;
         end
      end
      rx_if.rx_valid = 1'b0;
      n_cmp++;
      if (!seen) begin
         n_err++; $display("FAIL %s frame_done_timeout: got none after %0d cycles want %0d", name, cycles, exp_wave.size());
      end
      n_cmp++;
      if (werr != 0) begin
         n_err++; $display("FAIL %s waveform: got %0d bad cycles (first at %0d) want 0", name, werr, bad_at);
      end
      n_cmp++;
      if (cycles != exp_wave.size()) begin
         n_err++; $display("FAIL %s length: got %0d want %0d", name, cycles, exp_wave.size());
      end
      n_cmp++;
      if (bc_err != 0 || byte_count !== 4'd0) begin
         n_err++; $display("FAIL %s byte_count_during_play: got %0d bad cycles, now %0d want 0", name, bc_err, byte_count);
      end
      n_cmp++;
      if (busy !== 1'b0 || rep_count !== f[1] || pulse_out !== 1'b0) begin
         n_err++; $display("FAIL %s done_status: got busy=%0b rep=%0d pulse=%0b want 0/%0d/0", name, busy, rep_count, pulse_out, f[1]);
      end
      @(negedge clk);
      n_cmp++;
      if (frame_done !== 1'b0 || rep_count !== f[1] || busy !== 1'b0) begin
         n_err++; $display("FAIL %s after_done: got done=%0b rep=%0d busy=%0b want 0/%0d/0", name, frame_done, rep_count, busy, f[1]);
      end
   endtask

   task automatic test_reset();
      frame_t f;
      int cyc;
      rst_n = 1'b0;
      rx_if.rx_valid = 1'b0;
      rx_if.rx_byte  = 8'h00;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({pulse_out, busy, byte_count, rep_count, frame_done} !== 15'd0 || dut.w_cfg !== '0) begin
         n_err++; $display("FAIL reset_state: got pulse=%0b busy=%0b bc=%0d rep=%0d done=%0b want all 0", pulse_out, busy, byte_count, rep_count, frame_done);
      end
      rst_n = 1'b1;
      f = '{8'hA5, 8'h02, 8'h00, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h05};
      send_frame(f);
      repeat (20) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL reset_pre_busy: got %0b want 1", busy);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({pulse_out, busy, byte_count, rep_count, frame_done} !== 15'd0) begin
         n_err++; $display("FAIL reset_mid_play: got pulse=%0b busy=%0b bc=%0d rep=%0d want all 0", pulse_out, busy, byte_count, rep_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rx_if.rx_valid = 1'b1;
         rx_if.rx_byte  = 8'($urandom);
      end
      @(negedge clk);
      rx_if.rx_valid = 1'b0;
      n_cmp++;
      if (byte_count !== 4'd4) begin
         n_err++; $display("FAIL partial_load: got %0d want 4", byte_count);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (byte_count !== 4'd0) begin
         n_err++; $display("FAIL reset_mid_frame: got %0d want 0", byte_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(f);
      run_playback("after_reset", f, 1'b0, cyc);
   endtask

   task automatic test_basic_frame();
      frame_t f;
      int cyc;
      f = '{8'hA5, 8'h02, 8'h00, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h05};
      send_frame(f);
      run_playback("frame_a5", f, 1'b0, cyc);
      n_cmp++;
      if (cyc != 78) begin
         n_err++; $display("FAIL frame_a5_total: got %0d want 78", cyc);
      end
   endtask

   task automatic test_rep_zero();
      frame_t f;
      int bad;
      f = '{8'($urandom), 8'h00, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
      send_frame(f);
      n_cmp++;
      if (byte_count !== 4'd10 || busy !== 1'b0 || frame_done !== 1'b0) begin
         n_err++; $display("FAIL rep0_latch: got bc=%0d busy=%0b done=%0b want 10/0/0", byte_count, busy, frame_done);
      end
      @(negedge clk);
      n_cmp++;
      if (frame_done !== 1'b1 || busy !== 1'b0 || pulse_out !== 1'b0 || byte_count !== 4'd0) begin
         n_err++; $display("FAIL rep0_done: got done=%0b busy=%0b pulse=%0b bc=%0d want 1/0/0/0", frame_done, busy, pulse_out, byte_count);
      end
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (frame_done !== 1'b0 || busy !== 1'b0 || pulse_out !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++; $display("FAIL rep0_quiet: got %0d active cycles want 0", bad);
      end
   endtask

   task automatic test_zero_durations();
      frame_t f;
      int cyc;
      f = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(f);
      run_playback("zero_dur", f, 1'b0, cyc);
      n_cmp++;
      if (cyc != 18) begin
         n_err++; $display("FAIL zero_dur_total: got %0d want 18", cyc);
      end
   endtask

   task automatic test_random_frames();
      frame_t f;
      int cyc;
      for (int it = 0; it < 8; it++) begin
         f[0] = 8'($urandom);
         f[1] = 8'($urandom_range(1, 3));
         for (int k = 2; k < 10; k += 2) begin
            f[k]   = 8'h00;
            f[k+1] = 8'($urandom_range(0, 4));
         end
         send_frame(f);
         n_cmp++;
         if (rep_count !== 8'd0) begin
            n_err++; $display("FAIL rand%0d rep_clear: got %0d want 0", it, rep_count);
         end
         run_playback($sformatf("rand%0d", it), f, INJECT_OK && it[0], cyc);
      end
   endtask

   task automatic test_fields();
      frame_t f;
      f = '{8'h64, 8'h32, 8'h34, 8'h08, 8'h84, 8'h03, 8'h98, 8'h3A, 8'h50, 8'hC3};
      send_frame(f);
      n_cmp++;
      if (dut.w_cfg.tele !== 8'h64 || dut.w_cfg.rep_no !== 8'h32) begin
         n_err++; $display("FAIL fields_tele_rep: got %h/%h want 64/32", dut.w_cfg.tele, dut.w_cfg.rep_no);
      end
      n_cmp++;
      if (dut.w_cfg.t_high !== 16'h3408 || dut.w_cfg.t_low !== 16'h8403) begin
         n_err++; $display("FAIL fields_high_low: got %h/%h want 3408/8403", dut.w_cfg.t_high, dut.w_cfg.t_low);
      end
      n_cmp++;
      if (dut.w_cfg.t_imp !== 16'h983A || dut.w_cfg.t_stop !== 16'h50C3) begin
         n_err++; $display("FAIL fields_imp_stop: got %h/%h want 983A/50C3", dut.w_cfg.t_imp, dut.w_cfg.t_stop);
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || pulse_out !== 1'b1) begin
         n_err++; $display("FAIL fields_start: got busy=%0b pulse=%0b want 1/1", busy, pulse_out);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_rep_zero();
      test_zero_durations();
      test_random_frames();
      test_fields();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
